// File: rtl/vga_pkg.sv
// Shared definitions for the 160x120, 3-bit-colour VGA adapter datapath:
// screen geometry, named colours and the rect_fill state encoding.
package vga_pkg;

    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;

    localparam logic [2:0] BLACK   = 3'd0;
    localparam logic [2:0] BLUE    = 3'd1;
    localparam logic [2:0] GREEN   = 3'd2;
    localparam logic [2:0] CYAN    = 3'd3;
    localparam logic [2:0] RED     = 3'd4;
    localparam logic [2:0] MAGENTA = 3'd5;
    localparam logic [2:0] YELLOW  = 3'd6;
    localparam logic [2:0] WHITE   = 3'd7;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_SETUP = 2'd1,
        RF_DRAW  = 2'd2,
        RF_FIN   = 2'd3
    } rf_state_t;

endpackage

// File: rtl/xy_counter.sv
// Loadable 2-D raster counter. On load it takes an origin and a non-zero
// extent; each step advances x, wrapping back to the origin column and
// bumping y after the last column. Holds its position when not stepping.
module xy_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] org_x,
    input  logic [Y_W-1:0] org_y,
    input  logic [X_W:0]   wc,
    input  logic [Y_W:0]   hc,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last_col,
    output logic           last_pix
);

    logic [X_W-1:0] base_x;
    logic [X_W-1:0] end_x;
    logic [Y_W-1:0] end_y;
    logic [X_W:0]   end_x_full;
    logic [Y_W:0]   end_y_full;

    // Inclusive end coordinates of the rectangle; extent is never zero when loaded.
    always_comb begin
        end_x_full = {1'b0, org_x} + wc - (X_W+1)'(1);
        end_y_full = {1'b0, org_y} + hc - (Y_W+1)'(1);
    end

    // Bounds are pure data captured at load time, no reset needed.
    always_ff @(posedge clk) begin
        if (load) begin
            base_x <= org_x;
            end_x  <= end_x_full[X_W-1:0];
            end_y  <= end_y_full[Y_W-1:0];
        end
    end

    // Current raster position with row wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= org_x;
            y <= org_y;
        end else if (step) begin
            if (last_col) begin
                x <= base_x;
                y <= y + (Y_W)'(1);
            end else begin
                x <= x + (X_W)'(1);
            end
        end
    end

    assign last_col = (x == end_x);
    assign last_pix = last_col && (y == end_y);

endmodule

// File: rtl/rect_fill.sv
// Rectangle pixel-stream generator for the VGA adapter. Accepts one command
// in IDLE, clips it to the screen in SETUP, then emits one pixel per clock
// in row-major order and pulses done when the rectangle is complete.
module rect_fill import vga_pkg::*; #(
    parameter int X_W   = vga_pkg::X_W,
    parameter int Y_W   = vga_pkg::Y_W,
    parameter int X_MAX = vga_pkg::X_MAX,
    parameter int Y_MAX = vga_pkg::Y_MAX
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           start,
    input  logic           clear,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    input  logic [2:0]     colour_in,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour,
    output logic           plot
);

    localparam logic [X_W:0] XM = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] YM = (Y_W+1)'(Y_MAX);

    // Width visible on screen from origin org; one extra bit so org+len never wraps.
    function automatic logic [X_W:0] clip_w(input logic [X_W-1:0] org,
                                            input logic [X_W-1:0] len);
        logic [X_W:0] room;
        room = XM - {1'b0, org};
        if ({1'b0, org} >= XM)
            clip_w = '0;
        else if ({1'b0, len} < room)
            clip_w = {1'b0, len};
        else
            clip_w = room;
    endfunction

    // Height visible on screen from origin org.
    function automatic logic [Y_W:0] clip_h(input logic [Y_W-1:0] org,
                                            input logic [Y_W-1:0] len);
        logic [Y_W:0] room;
        room = YM - {1'b0, org};
        if ({1'b0, org} >= YM)
            clip_h = '0;
        else if ({1'b0, len} < room)
            clip_h = {1'b0, len};
        else
            clip_h = room;
    endfunction

    rf_state_t      state;
    logic           cmd_clear;
    logic [X_W-1:0] cmd_x0;
    logic [Y_W-1:0] cmd_y0;
    logic [X_W-1:0] cmd_w;
    logic [Y_W-1:0] cmd_h;
    logic [2:0]     cmd_colour;

    logic [X_W-1:0] org_x;
    logic [Y_W-1:0] org_y;
    logic [X_W:0]   wc;
    logic [Y_W:0]   hc;
    logic           empty;
    logic           cnt_load;
    logic           cnt_step;
    logic           cnt_last_col;
    logic           cnt_last_pix;
    logic           frame_end;

    // Command registers are data only; they are captured on acceptance.
    always_ff @(posedge CLOCK_50) begin
        if (state == RF_IDLE && start) begin
            cmd_clear  <= clear;
            cmd_x0     <= x0;
            cmd_y0     <= y0;
            cmd_w      <= w;
            cmd_h      <= h;
            cmd_colour <= colour_in;
        end
    end

    // Clipped origin and extent from the latched command; clear overrides everything.
    always_comb begin
        org_x = '0;
        org_y = '0;
        wc    = XM;
        hc    = YM;
        if (!cmd_clear) begin
            org_x = cmd_x0;
            org_y = cmd_y0;
            wc    = clip_w(cmd_x0, cmd_w);
            hc    = clip_h(cmd_y0, cmd_h);
        end
        empty = (wc == '0) || (hc == '0);
    end

    assign cnt_load  = (state == RF_SETUP) && !empty;
    assign cnt_step  = (state == RF_DRAW) && !cnt_last_pix;
    // The final pixel is the last column of the last row.
    assign frame_end = cnt_last_col && cnt_last_pix;

    xy_counter #(
        .X_W(X_W),
        .Y_W(Y_W)
    ) u_xy_counter (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .load     (cnt_load),
        .step     (cnt_step),
        .org_x    (org_x),
        .org_y    (org_y),
        .wc       (wc),
        .hc       (hc),
        .x        (x),
        .y        (y),
        .last_col (cnt_last_col),
        .last_pix (cnt_last_pix)
    );

    // Command FSM with registered busy/done/plot/colour outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state  <= RF_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            colour <= '0;
        end else begin
            case (state)
                RF_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RF_SETUP;
                        busy  <= 1'b1;
                    end
                end
                RF_SETUP: begin
                    if (empty) begin
                        state <= RF_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state  <= RF_DRAW;
                        plot   <= 1'b1;
                        colour <= cmd_colour;
                    end
                end
                RF_DRAW: begin
                    if (frame_end) begin
                        state <= RF_FIN;
                        plot  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                RF_FIN: begin
                    done  <= 1'b0;
                    state <= RF_IDLE;
                end
                default: begin
                    state <= RF_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    plot  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: small, empty, clipped, full-clear, ignored
// start and mid-draw reset scenarios with hand-computed expectations.
module tb_rect_fill;
    import vga_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic       clear    = 1'b0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [7:0] w  = '0;
    logic [6:0] h  = '0;
    logic [2:0] colour_in = '0;
    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int checks = 0;
    int errors = 0;

    int qx[$];
    int qy[$];
    int qc[$];
    int plot_cnt, first_plot, last_plot, done_at, done_cnt, busy_cnt, busy_at_done, off_screen;

    rect_fill dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .clear    (clear),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .colour_in(colour_in),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic issue(input logic clr, input int ax, input int ay, input int aw,
                         input int ah, input logic [2:0] col);
        @(negedge CLOCK_50);
        clear     = clr;
        x0        = ax[7:0];
        y0        = ay[6:0];
        w         = aw[7:0];
        h         = ah[6:0];
        colour_in = col;
        start     = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
    endtask

    // Records outputs once per cycle after acceptance (k=1 is the SETUP cycle).
    task automatic capture(input int limit);
        qx.delete(); qy.delete(); qc.delete();
        plot_cnt = 0; first_plot = 0; last_plot = 0; done_at = 0;
        done_cnt = 0; busy_cnt = 0; busy_at_done = -1; off_screen = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge CLOCK_50);
            if (plot === 1'b1) begin
                qx.push_back(int'(x));
                qy.push_back(int'(y));
                qc.push_back(int'(colour));
                if (first_plot == 0) first_plot = k;
                last_plot = k;
                plot_cnt++;
                if (x >= 8'd160 || y >= 7'd120) off_screen++;
            end
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at      = k;
                    busy_at_done = int'(busy);
                end
            end
            if (done_at != 0 && k >= done_at + 3) break;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if ({busy, done, plot} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/plot=%b required 000", {busy, done, plot});
        end
        checks++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: x=%0d y=%0d colour=%0d required 0 0 0", x, y, colour);
        end
        resetn = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic test_small_rect;
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{5, 5, 6, 6};
        issue(1'b0, 10, 5, 2, 2, CYAN);
        capture(50);
        checks++;
        if (plot_cnt !== 4) begin errors++; $display("FAIL small_plots: got %0d required 4", plot_cnt); end
        checks++;
        if (first_plot !== 2 || last_plot !== 5) begin
            errors++; $display("FAIL small_window: plots %0d..%0d required 2..5", first_plot, last_plot);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= qx.size() || qx[i] !== ex[i] || qy[i] !== ey[i] || qc[i] !== 3) begin
                errors++;
                $display("FAIL small_pix%0d: got (%0d,%0d) c%0d required (%0d,%0d) c3", i,
                         (i < qx.size()) ? qx[i] : -1, (i < qy.size()) ? qy[i] : -1,
                         (i < qc.size()) ? qc[i] : -1, ex[i], ey[i]);
            end
        end
        checks++;
        if (done_at !== 6) begin errors++; $display("FAIL small_done_at: got %0d required 6", done_at); end
        checks++;
        if (busy_cnt !== 5) begin errors++; $display("FAIL small_busy_cycles: got %0d required 5", busy_cnt); end
        checks++;
        if (busy_at_done !== 0) begin errors++; $display("FAIL small_busy_at_done: got %0d required 0", busy_at_done); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL small_done_count: got %0d required 1", done_cnt); end
        checks++;
        if (x !== 8'd11 || y !== 7'd6 || colour !== 3'd3) begin
            errors++; $display("FAIL small_hold: got (%0d,%0d) c%0d required (11,6) c3", x, y, colour);
        end
    endtask

    task automatic test_empty;
        issue(1'b0, 0, 0, 0, 7, WHITE);
        capture(20);
        checks++;
        if (plot_cnt !== 0) begin errors++; $display("FAIL empty_w_plots: got %0d required 0", plot_cnt); end
        checks++;
        if (done_at !== 2) begin errors++; $display("FAIL empty_w_done_at: got %0d required 2", done_at); end
        checks++;
        if (busy_cnt !== 1) begin errors++; $display("FAIL empty_w_busy: got %0d required 1", busy_cnt); end
        issue(1'b0, 200, 10, 5, 5, RED);
        capture(20);
        checks++;
        if (plot_cnt !== 0 || done_at !== 2) begin
            errors++; $display("FAIL empty_x_off: plots %0d done_at %0d required 0 and 2", plot_cnt, done_at);
        end
        issue(1'b0, 10, 120, 3, 3, RED);
        capture(20);
        checks++;
        if (plot_cnt !== 0 || done_at !== 2) begin
            errors++; $display("FAIL empty_y_off: plots %0d done_at %0d required 0 and 2", plot_cnt, done_at);
        end
    endtask

    task automatic test_clip_corner;
        int ex[4] = '{158, 159, 158, 159};
        int ey[4] = '{118, 118, 119, 119};
        int bad;
        issue(1'b0, 158, 118, 5, 5, YELLOW);
        capture(50);
        checks++;
        if (plot_cnt !== 4) begin errors++; $display("FAIL corner_plots: got %0d required 4", plot_cnt); end
        checks++;
        if (off_screen !== 0) begin errors++; $display("FAIL corner_offscreen: got %0d required 0", off_screen); end
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= qx.size() || qx[i] !== ex[i] || qy[i] !== ey[i] || qc[i] !== 6) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL corner_sequence: %0d wrong pixels required 0", bad); end
        checks++;
        if (done_at !== 6) begin errors++; $display("FAIL corner_done_at: got %0d required 6", done_at); end
    endtask

    task automatic test_clear;
        int bad;
        issue(1'b1, 50, 60, 3, 3, BLACK);
        capture(19300);
        checks++;
        if (plot_cnt !== 19200) begin errors++; $display("FAIL clear_plots: got %0d required 19200", plot_cnt); end
        checks++;
        if (first_plot !== 2 || last_plot !== 19201) begin
            errors++; $display("FAIL clear_window: plots %0d..%0d required 2..19201", first_plot, last_plot);
        end
        bad = 0;
        for (int i = 0; i < 19200; i++)
            if (i >= qx.size() || qx[i] !== i % 160 || qy[i] !== i / 160 || qc[i] !== 0) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL clear_raster: %0d wrong pixels required 0", bad); end
        checks++;
        if (done_at !== 19202) begin errors++; $display("FAIL clear_done_at: got %0d required 19202", done_at); end
    endtask

    task automatic test_start_ignored;
        int bad;
        issue(1'b0, 20, 30, 10, 10, MAGENTA);
        fork
            capture(300);
            begin
                repeat (6) @(negedge CLOCK_50);
                clear = 1'b0; x0 = 8'd0; y0 = 7'd0; w = 8'd50; h = 7'd50; colour_in = BLUE;
                start = 1'b1;
                repeat (3) @(negedge CLOCK_50);
                start = 1'b0;
            end
        join
        checks++;
        if (plot_cnt !== 100) begin errors++; $display("FAIL ignore_plots: got %0d required 100", plot_cnt); end
        bad = 0;
        for (int i = 0; i < 100; i++)
            if (i >= qx.size() || qx[i] !== 20 + i % 10 || qy[i] !== 30 + i / 10 || qc[i] !== 5) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL ignore_sequence: %0d wrong pixels required 0", bad); end
        checks++;
        if (done_cnt !== 1 || done_at !== 102) begin
            errors++; $display("FAIL ignore_done: count %0d at %0d required 1 at 102", done_cnt, done_at);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        issue(1'b0, 40, 50, 10, 10, WHITE);
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if (plot !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midreset_active: plot=%b busy=%b required 1 1", plot, busy);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            errors++; $display("FAIL midreset_async_ctrl: plot/busy/done=%b required 000", {plot, busy, done});
        end
        checks++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
            errors++; $display("FAIL midreset_async_data: x=%0d y=%0d c=%0d required 0 0 0", x, y, colour);
        end
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge CLOCK_50);
            if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL midreset_idle: %0d active cycles required 0", bad); end
        issue(1'b0, 1, 2, 3, 2, GREEN);
        capture(50);
        bad = 0;
        for (int i = 0; i < 6; i++)
            if (i >= qx.size() || qx[i] !== 1 + i % 3 || qy[i] !== 2 + i / 3 || qc[i] !== 2) bad++;
        checks++;
        if (plot_cnt !== 6 || bad !== 0) begin
            errors++; $display("FAIL midreset_fresh: plots %0d bad %0d required 6 and 0", plot_cnt, bad);
        end
        checks++;
        if (done_at !== 8) begin errors++; $display("FAIL midreset_fresh_done: got %0d required 8", done_at); end
    endtask

    initial begin
        test_reset();
        test_small_rect();
        test_empty();
        test_clip_corner();
        test_clear();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
